store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; power of two, 2..16.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_addr  input  32  byte address from pipeline MEM stage.
REQ-005 cpu_wdata  input  32  store data.
REQ-006 cpu_memwrite  input  1  store request.
REQ-007 cpu_memread  input  1  load request.
REQ-008 cpu_sign_mask  input  4  access size/sign code, passed through unchanged.
REQ-009 cpu_rdata  output  32  load result, valid in the cycle cpu_stall falls.
REQ-010 cpu_stall  output  1  combinational; pipeline holds the request while high.
REQ-011 mem_addr / mem_write_data  output  32 each  to data_mem addr / write_data.
REQ-012 mem_memwrite / mem_memread  output  1 each  single-cycle request pulses to data_mem.
REQ-013 mem_sign_mask  output  4  to data_mem sign_mask.
REQ-014 mem_read_data  input  32  from data_mem read_data.
REQ-015 mem_clk_stall  input  1  from data_mem clk_stall; high = access in progress.

Function
REQ-016 FIFO of DEPTH entries {addr, data, sign_mask}, head/tail pointers wrap modulo DEPTH, count 0..DEPTH.
REQ-017 Store with count<DEPTH: enqueued at the edge, cpu_stall=0 that cycle.
REQ-018 Store with count==DEPTH: cpu_stall=1 until a pop occurs; enqueue on the pop edge (count unchanged).
REQ-019 Drain FSM states IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT.
REQ-020 IDLE -> WR_ISSUE when count>0 and no load can issue; WR_ISSUE drives head entry with mem_memwrite=1 for exactly one cycle -> WR_WAIT.
REQ-021 WR_WAIT: stay while mem_clk_stall=1; on first cycle mem_clk_stall=0, pop head -> IDLE.
REQ-022 Load: cpu_stall=1 from the request cycle; load waits until count==0 (strict store->load ordering), then IDLE -> RD_ISSUE.
REQ-023 RD_ISSUE: mem_memread=1 with cpu_addr/cpu_sign_mask for one cycle -> RD_WAIT; RD_WAIT on mem_clk_stall=0 registers mem_read_data into cpu_rdata, cpu_stall=0 next cycle -> IDLE.
REQ-024 Load latency, empty buffer: cpu_stall high for 2 + N cycles, N = cycles mem_clk_stall is high.
REQ-025 cpu_memwrite and cpu_memread both high: treated as store only.
REQ-026 mem_* outputs held stable throughout WR_WAIT/RD_WAIT; mem_memwrite/mem_memread zero outside *_ISSUE.
REQ-027 cpu_rdata holds its last value between loads.

Reset
REQ-028 reset=1 at an edge: count=0, pointers=0, FSM=IDLE, cpu_rdata=0, all mem_* outputs 0, cpu_stall=0 while no request.
REQ-029 Reset mid-access: in-flight write or read abandoned, buffered stores discarded; no further mem pulse until new request.

Configuration
REQ-030 Macro STORE_BUFFER_FWD_EN defined: load with sign_mask 4'b1111 matching the youngest buffered entry's addr with sign_mask 4'b1111 returns that entry's data, cpu_stall high exactly one cycle, no mem access, buffer untouched.
REQ-031 STORE_BUFFER_FWD_EN undefined: every load follows REQ-022, no compare logic present.

Verification
REQ-032 After reset, store 0x1748 to 0x1001, mask 0010 -> no stall; one mem_memwrite pulse with addr 0x1001, data 0x1748; count 1 -> 0 after mem_clk_stall falls.
REQ-033 5 back-to-back stores, DEPTH=4, data_mem stalls 3 cycles -> 5th store stalls until first pop; writes reach data_mem in order 1..5.
REQ-034 Store 0xDEADBEEF to 0x100, immediate load 0x100 mask 1111, fwd off -> write completes before mem_memread; cpu_rdata=0xDEADBEEF.
REQ-035 Same with STORE_BUFFER_FWD_EN -> cpu_stall high 1 cycle, cpu_rdata=0xDEADBEEF, no mem_memread.
REQ-036 Load 0x200 empty buffer, mem_clk_stall high 4 cycles -> cpu_stall high 6 cycles, cpu_rdata=mem_read_data.
REQ-037 reset asserted during WR_WAIT with 3 entries -> count=0, FSM IDLE, no further mem pulses.

Source files
------------

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store FIFO between the pipeline MEM stage and data_mem.
// Define STORE_BUFFER_FWD_EN to forward the youngest full-word store to a matching load.

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic          load_done_q, load_done_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_mask_q, mem_mask_d;

  logic [31:0]   fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [3:0]    fifo_mask_q [DEPTH];

  logic load_req, full, pop, enq, fwd_hit;

  // A store alongside a load is treated as a store only.
  assign load_req = cpu_memread & ~cpu_memwrite;
  assign full     = (count_q == FULL);
  assign pop      = (state_q == WR_WAIT) && !mem_clk_stall;
  assign enq      = cpu_memwrite && (!full || pop);

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] young_idx;
  assign young_idx = tail_q - PW'(1);
  assign fwd_hit   = load_req && !load_done_q && (count_q != '0) &&
                     (cpu_sign_mask == 4'b1111) && (fifo_mask_q[young_idx] == 4'b1111) &&
                     (fifo_addr_q[young_idx] == cpu_addr);
`else
  assign fwd_hit = 1'b0;
`endif

  // load_done_q marks the single cycle in which a finished load is released.
  assign cpu_stall = (cpu_memwrite && full && !pop) || (load_req && !load_done_q);

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cpu_rdata_d = cpu_rdata_q;
    load_done_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;

    case (state_q)
      IDLE: begin
        if (load_req && (count_q == '0) && !load_done_q) begin
          state_d    = RD_ISSUE;
          mem_addr_d = cpu_addr;
          mem_mask_d = cpu_sign_mask;
        end else if (count_q != '0) begin
          state_d     = WR_ISSUE;
          mem_addr_d  = fifo_addr_q[head_q];
          mem_wdata_d = fifo_data_q[head_q];
          mem_mask_d  = fifo_mask_q[head_q];
        end
      end
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT: begin
        if (pop) begin
          head_d  = head_q + PW'(1);
          state_d = IDLE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (!mem_clk_stall) begin
          cpu_rdata_d = mem_read_data;
          load_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef STORE_BUFFER_FWD_EN
    if (fwd_hit) begin
      cpu_rdata_d = fifo_data_q[young_idx];
      load_done_d = 1'b1;
    end
`endif

    if (enq) tail_d = tail_q + PW'(1);
    count_d = count_q + CW'(enq) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cpu_rdata_q <= '0;
      load_done_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cpu_rdata_q <= cpu_rdata_d;
      load_done_q <= load_done_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
    end
  end

  // Entry storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr_q[tail_q] <= cpu_addr;
      fifo_data_q[tail_q] <= cpu_wdata;
      fifo_mask_q[tail_q] <= cpu_sign_mask;
    end
  end

  assign cpu_rdata      = cpu_rdata_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_sign_mask  = mem_mask_q;
  assign mem_memwrite   = (state_q == WR_ISSUE);
  assign mem_memread    = (state_q == RD_ISSUE);

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer.
// A small data_mem model raises mem_clk_stall for stall_n cycles starting at each request pulse.

module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_memwrite, cpu_memread, cpu_stall;
  logic [3:0]  cpu_sign_mask, mem_sign_mask;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread, mem_clk_stall;

  int checks = 0;
  int failures = 0;
  int stall_n = 0;
  int stall_left = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int wr_before_rd = 0;
  int n, rd0, wp0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [31:0] mem_model [logic [31:0]];

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_sign_mask(cpu_sign_mask), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: at the falling edge update the memory model, then apply cpu inputs.
  task automatic step(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    if (stall_left > 0) stall_left--;
    if (mem_memwrite) begin
      wr_pulses++;
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_write_data);
      mem_model[mem_addr] = mem_write_data;
      stall_left = stall_n;
    end
    if (mem_memread) begin
      rd_pulses++;
      last_rd_addr = mem_addr;
      wr_before_rd = wr_addr_log.size();
      mem_read_data = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
      stall_left = stall_n;
    end
    mem_clk_stall = (stall_left > 0);
    cpu_memwrite  = w;
    cpu_memread   = r;
    cpu_addr      = a;
    cpu_wdata     = d;
    cpu_sign_mask = m;
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    reset = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_memwrite = 1'b0; cpu_memread = 1'b0;
    cpu_sign_mask = '0; mem_read_data = '0; mem_clk_stall = 1'b0;

    // Reset state
    idle(3);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_memwrite", 32'(mem_memwrite), 32'd0);
    chk("rst_memread", 32'(mem_memread), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_count", 32'(dut.count_q), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'd0);
    reset = 1'b0;
    idle(1);

    // Store and load together behave as a store
    stall_n = 0;
    wr_addr_log.delete(); wr_data_log.delete();
    rd0 = rd_pulses;
    step(1'b1, 1'b1, 32'h300, 32'h33, 4'b1111);
    chk("both_stall", 32'(cpu_stall), 32'd0);
    idle(6);
    chk("both_wr_count", 32'(wr_addr_log.size()), 32'd1);
    chk("both_wr_addr", wr_addr_log[0], 32'h300);
    chk("both_no_read", 32'(rd_pulses - rd0), 32'd0);

    // Single store with a 2-cycle data_mem stall
    stall_n = 2;
    wr_addr_log.delete(); wr_data_log.delete();
    step(1'b1, 1'b0, 32'h1001, 32'h1748, 4'b0010);
    chk("st1_stall", 32'(cpu_stall), 32'd0);
    idle(1);
    chk("st1_count1", 32'(dut.count_q), 32'd1);
    idle(1);
    chk("st1_memwrite", 32'(mem_memwrite), 32'd1);
    chk("st1_addr", mem_addr, 32'h1001);
    chk("st1_data", mem_write_data, 32'h1748);
    chk("st1_mask", 32'(mem_sign_mask), 32'h2);
    idle(1);
    chk("st1_pulse_end", 32'(mem_memwrite), 32'd0);
    chk("st1_addr_held", mem_addr, 32'h1001);
    chk("st1_count_wait", 32'(dut.count_q), 32'd1);
    idle(5);
    chk("st1_count0", 32'(dut.count_q), 32'd0);
    chk("st1_wr_count", 32'(wr_addr_log.size()), 32'd1);

    // Five back-to-back stores into a 4-deep buffer, 3-cycle data_mem stall
    stall_n = 3;
    wr_addr_log.delete(); wr_data_log.delete();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 32'(32'h2000 + 4 * i), 32'(32'hA0 + i), 4'b0100);
      n = 0;
      while (cpu_stall && n < 50) begin
        n++;
        step(1'b1, 1'b0, 32'(32'h2000 + 4 * i), 32'(32'hA0 + i), 4'b0100);
      end
      chk($sformatf("b2b_stall%0d", i), 32'(n), (i == 5) ? 32'd1 : 32'd0);
    end
    idle(40);
    chk("b2b_wr_count", 32'(wr_addr_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("b2b_addr%0d", i + 1), wr_addr_log[i], 32'(32'h2004 + 4 * i));
      chk($sformatf("b2b_data%0d", i + 1), wr_data_log[i], 32'(32'hA1 + i));
    end
    chk("b2b_count0", 32'(dut.count_q), 32'd0);

    // Store then immediate load of the same word
    stall_n = 2;
    wr_addr_log.delete(); wr_data_log.delete();
    rd0 = rd_pulses;
    step(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111);
    chk("raw_store_stall", 32'(cpu_stall), 32'd0);
    step(1'b0, 1'b1, 32'h100, 32'h0, 4'b1111);
    n = 0;
    while (cpu_stall && n < 50) begin
      n++;
      step(1'b0, 1'b1, 32'h100, 32'h0, 4'b1111);
    end
`ifdef STORE_BUFFER_FWD_EN
    chk("raw_fwd_stall", 32'(n), 32'd1);
    chk("raw_fwd_no_read", 32'(rd_pulses - rd0), 32'd0);
`else
    chk("raw_read_count", 32'(rd_pulses - rd0), 32'd1);
    chk("raw_write_first", 32'(wr_before_rd), 32'd1);
`endif
    chk("raw_rdata", cpu_rdata, 32'hDEADBEEF);
    idle(10);
    chk("raw_rdata_held", cpu_rdata, 32'hDEADBEEF);
    chk("raw_count0", 32'(dut.count_q), 32'd0);

    // Load from empty buffer, 4-cycle stall: 6 stall cycles
    stall_n = 4;
    mem_model[32'h200] = 32'h5A5A0200;
    rd0 = rd_pulses;
    step(1'b0, 1'b1, 32'h200, 32'h0, 4'b0010);
    n = 0;
    while (cpu_stall && n < 50) begin
      n++;
      step(1'b0, 1'b1, 32'h200, 32'h0, 4'b0010);
    end
    chk("ld4_stall_cycles", 32'(n), 32'd6);
    chk("ld4_rdata", cpu_rdata, 32'h5A5A0200);
    chk("ld4_rd_addr", last_rd_addr, 32'h200);
    chk("ld4_read_count", 32'(rd_pulses - rd0), 32'd1);
    idle(3);

    // Load with a 1-cycle stall: 3 stall cycles
    stall_n = 1;
    step(1'b0, 1'b1, 32'h100, 32'h0, 4'b0010);
    n = 0;
    while (cpu_stall && n < 50) begin
      n++;
      step(1'b0, 1'b1, 32'h100, 32'h0, 4'b0010);
    end
    chk("ld1_stall_cycles", 32'(n), 32'd3);
    chk("ld1_rdata", cpu_rdata, 32'hDEADBEEF);
    idle(3);

    // Reset during WR_WAIT with three buffered stores
    stall_n = 20;
    step(1'b1, 1'b0, 32'h400, 32'h11, 4'b1111);
    step(1'b1, 1'b0, 32'h404, 32'h22, 4'b1111);
    step(1'b1, 1'b0, 32'h408, 32'h33, 4'b1111);
    idle(2);
    chk("mid_state_wait", 32'(dut.state_q), 32'd2);
    chk("mid_count3", 32'(dut.count_q), 32'd3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("mid_count0", 32'(dut.count_q), 32'd0);
    chk("mid_state_idle", 32'(dut.state_q), 32'd0);
    chk("mid_memwrite", 32'(mem_memwrite), 32'd0);
    chk("mid_stall", 32'(cpu_stall), 32'd0);
    wp0 = wr_pulses;
    rd0 = rd_pulses;
    idle(30);
    chk("mid_no_writes", 32'(wr_pulses - wp0), 32'd0);
    chk("mid_no_reads", 32'(rd_pulses - rd0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
